fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the 256x16 instruction ROM and the decode/register stage.
- Holds the program counter and drives the ROM address combinationally.
- Latches the returned 16-bit word into an instruction register with its PC and a valid flag.
- Handles jump, relative branch, call/return (hardware return stack), stall and halt/resume.

Parameters:
- ADDR_W, 8, PC and ROM address width
- INSTR_W, 16, instruction word width
- RESET_PC, 8'h00, PC value after reset and after return-stack underflow
- STACK_DEPTH, 4, return-stack entries (power of two, 2..16)

Ports:
- nclk  input  1  system clock; all state updates on falling edge
- nreset  input  1  asynchronous, active-low reset
- rom_addr  output  ADDR_W  ROM address, equals pc (combinational)
- rom_data  input  INSTR_W  ROM word at rom_addr, combinational
- stall  input  1  hold all state this edge
- halt  input  1  request entry to HALT
- resume  input  1  leave HALT
- jump  input  1  absolute redirect to jump_target
- jump_target  input  ADDR_W  absolute target for jump/call
- branch  input  1  relative redirect
- branch_offset  input  ADDR_W  signed two's-complement offset
- call  input  1  push return address, go to jump_target
- ret  input  1  pop return address into pc
- instr  output  INSTR_W  instruction register
- instr_pc  output  ADDR_W  address instr was fetched from
- instr_valid  output  1  instr is on the correct path
- halted  output  1  FSM in HALT
- stack_overflow  output  1  sticky, call with full stack
- stack_underflow  output  1  sticky, ret with empty stack

Behaviour:
- Reset (nreset=0, asynchronous): pc=RESET_PC; instr=0; instr_pc=0; instr_valid=0; halted=0; stack pointer=0; both sticky flags=0; FSM=RUN. Deassertion takes effect at the next falling edge.
- FSM states:
  - RUN: fetching.
  - HALT: pc, instr and instr_pc frozen; instr_valid=0; halted=1.
- FSM transitions:
  - RUN->HALT on an edge with halt=1 and stall=0. That edge behaves as a flush: instr_valid<=0, pc unchanged.
  - HALT->RUN on an edge with resume=1. Fetch resumes from the held pc; the first valid instr appears at the edge after that.
  - In HALT: stall, redirect, call and ret are ignored.
- Stall (RUN, stall=1): every register holds, including the stack. Redirect inputs are ignored; the requester must hold them until stall=0. Stall outranks halt.
- RUN, stall=0, no redirect:
  - instr<=rom_data; instr_pc<=pc; instr_valid<=1; pc<=pc+1.
  - pc wraps from 8'hFF to 8'h00.
  - Latency: ROM address to instr is one falling edge.
- Redirect priority: ret > call > jump > branch (then halt). Only the highest-priority request acts.
- On any redirect edge: instr_valid<=0 (the word at the old pc is wrong-path and is discarded); instr and instr_pc hold; pc<=target.
- Redirect targets:
  - ret: pc<=stack top; pointer decrements.
  - call: push instr_pc+1 (mod 256); pc<=jump_target.
  - jump: pc<=jump_target.
  - branch: pc<=instr_pc + sign-extended branch_offset, modulo 2^ADDR_W (relative to the redirecting instruction).
- Stack boundary conditions:
  - call with STACK_DEPTH entries already held: jump still taken; push dropped; stack_overflow<=1.
  - ret with empty stack: pc<=RESET_PC; stack_underflow<=1; pointer stays 0.
  - Sticky flags clear only on reset.
- Back-to-back redirects are legal; each is honoured on its own edge.

Optional Feature:
- Macro: FETCH_CALL_STACK_EN
- Defined: return stack, call, ret and both sticky flags behave as above.
- Undefined:
  - No stack storage; call and ret are ignored (treated as 0).
  - stack_overflow and stack_underflow are tied 0.
  - jump, branch, stall and halt are unchanged.

Test Plan:
- Reset and sequential fetch: release nreset with ROM[n]=16'hA000+n. After edge 1, instr=16'hA000, instr_pc=0, instr_valid=1; after edge 3, instr_pc=2, rom_addr=3.
- PC wrap: run from pc=8'hFE. instr_pc sequence is FE, FF, 00 with instr_valid=1 throughout.
- Jump flush: jump=1, jump_target=8'h40 for one edge while instr_pc=5. That edge gives instr_valid=0 and instr_pc still 5; next edge gives instr_pc=8'h40, instr_valid=1.
- Backward branch: branch=1 with branch_offset=8'hFC while instr_pc=8'h10. Next valid instr_pc=8'h0C; an offset of 8'h80 at instr_pc=8'h10 gives 8'h90.
- Call/return and overflow (macro defined):
  - Nested calls from instr_pc 1, 2, 3, 4 to 8'h20: the 5th call sets stack_overflow.
  - Four rets return to 5, 4, 3, 2.
  - A 5th ret goes to RESET_PC and sets stack_underflow.
- Stall, halt and priority:
  - stall=1 for 3 edges: all outputs constant, and a jump asserted during stall is not taken.
  - halt=1: halted=1, instr_valid=0. resume=1: next fetch continues from the held pc.
  - call and jump on the same edge: the call is taken (priority over jump).
  - nreset pulsed mid-stack: all registers return to reset values immediately, without waiting for an edge.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage in front of the instruction ROM.
// Holds the PC, latches ROM words into the instruction register and handles
// jump / branch / call / ret redirects, stall and halt/resume.
// All state updates on the falling edge of nclk; nreset is async active-low.
// Optional feature macro: FETCH_CALL_STACK_EN (hardware return stack,
// call/ret and the sticky stack_overflow/stack_underflow flags). When it is
// undefined, call and ret are ignored and both flags are tied low.
module fetch_unit #(
  parameter int unsigned       ADDR_W      = 8,
  parameter int unsigned       INSTR_W     = 16,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int unsigned       STACK_DEPTH = 4
) (
  input  logic               nclk,
  input  logic               nreset,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  input  logic               stall,
  input  logic               halt,
  input  logic               resume,
  input  logic               jump,
  input  logic [ADDR_W-1:0]  jump_target,
  input  logic               branch,
  input  logic [ADDR_W-1:0]  branch_offset,
  input  logic               call,
  input  logic               ret,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  output logic               halted,
  output logic               stack_overflow,
  output logic               stack_underflow
);

  typedef enum logic {RUN, HALT} state_t;

  state_t             state, state_n;
  logic [ADDR_W-1:0]  pc, pc_n;
  logic [INSTR_W-1:0] instr_n;
  logic [ADDR_W-1:0]  instr_pc_n;
  logic               instr_valid_n;

`ifdef FETCH_CALL_STACK_EN
  localparam int unsigned IDX_W = $clog2(STACK_DEPTH);
  localparam int unsigned SP_W  = IDX_W + 1;

  logic [ADDR_W-1:0] stack [STACK_DEPTH];
  logic [SP_W-1:0]   sp, sp_n;
  logic              overflow_q, overflow_n;
  logic              underflow_q, underflow_n;
  logic              push_en;
  logic [ADDR_W-1:0] push_data;
  logic [IDX_W-1:0]  top_idx;
  logic [IDX_W-1:0]  push_idx;

  assign top_idx         = IDX_W'(sp - SP_W'(1));
  assign push_idx        = IDX_W'(sp);
  assign stack_overflow  = overflow_q;
  assign stack_underflow = underflow_q;
`else
  localparam int unsigned unused_stack_depth = STACK_DEPTH;
  logic unused_stack_inputs;

  assign unused_stack_inputs = ^{call, ret};
  assign stack_overflow      = 1'b0;
  assign stack_underflow     = 1'b0;
`endif

  assign rom_addr = pc;
  assign halted   = (state == HALT);

  // FSM state register
  always_ff @(negedge nclk or negedge nreset) begin
    if (!nreset) state <= RUN;
    else         state <= state_n;
  end

  // Next-state, next-PC and instruction-register update selection
  always_comb begin
    state_n       = state;
    pc_n          = pc;
    instr_n       = instr;
    instr_pc_n    = instr_pc;
    instr_valid_n = instr_valid;
`ifdef FETCH_CALL_STACK_EN
    sp_n          = sp;
    overflow_n    = overflow_q;
    underflow_n   = underflow_q;
    push_en       = 1'b0;
    push_data     = instr_pc + ADDR_W'(1);
`endif
    unique case (state)
      RUN: begin
        if (!stall) begin
          // Every non-fetch edge (redirect or halt entry) discards the word.
          instr_valid_n = 1'b0;
`ifdef FETCH_CALL_STACK_EN
          if (ret) begin
            if (sp == '0) begin
              pc_n        = RESET_PC;
              underflow_n = 1'b1;
            end else begin
              pc_n = stack[top_idx];
              sp_n = sp - SP_W'(1);
            end
          end else if (call) begin
            pc_n = jump_target;
            if (sp == SP_W'(STACK_DEPTH)) begin
              overflow_n = 1'b1;
            end else begin
              push_en = 1'b1;
              sp_n    = sp + SP_W'(1);
            end
          end else
`endif
          if (jump) begin
            pc_n = jump_target;
          end else if (branch) begin
            // Same-width modular add equals sign-extended offset mod 2^ADDR_W.
            pc_n = instr_pc + branch_offset;
          end else if (halt) begin
            state_n = HALT;
          end else begin
            instr_n       = rom_data;
            instr_pc_n    = pc;
            instr_valid_n = 1'b1;
            pc_n          = pc + ADDR_W'(1);
          end
        end
      end
      HALT: begin
        if (resume) state_n = RUN;
      end
      default: state_n = RUN;
    endcase
  end

  // PC and instruction register
  always_ff @(negedge nclk or negedge nreset) begin
    if (!nreset) begin
      pc          <= RESET_PC;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else begin
      pc          <= pc_n;
      instr       <= instr_n;
      instr_pc    <= instr_pc_n;
      instr_valid <= instr_valid_n;
    end
  end

`ifdef FETCH_CALL_STACK_EN
  // Return-stack pointer and sticky error flags
  always_ff @(negedge nclk or negedge nreset) begin
    if (!nreset) begin
      sp          <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      sp          <= sp_n;
      overflow_q  <= overflow_n;
      underflow_q <= underflow_n;
    end
  end

  // Return-stack storage; entries above the pointer are don't-care
  always_ff @(negedge nclk) begin
    if (push_en) stack[push_idx] <= push_data;
  end
`endif

endmodule
